// File: rtl/bram_io_ctrl.sv
// Coefficient stream-in/stream-out controller sharing one BRAM with the multiplier core.
// Optional macro BRAM_IO_RANGECHK_EN adds a sticky err output for loaded coefficients >= 3329.
module bram_io_ctrl #(
    parameter int LENBR = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_start,
    input  logic        unload_start,
    output logic        busy,
    output logic        done,
    input  logic        s_valid,
    input  logic [11:0] s_data,
    output logic        s_ready,
    output logic        m_valid,
    output logic [11:0] m_data,
    output logic        m_last,
    input  logic        m_ready,
    input  logic        core_wen,
    input  logic [7:0]  core_waddr,
    input  logic [11:0] core_din,
    input  logic [7:0]  core_raddr,
    output logic [11:0] core_dout,
    output logic        bram_wen,
    output logic [7:0]  bram_waddr,
    output logic [11:0] bram_din,
    output logic [7:0]  bram_raddr,
    input  logic [11:0] bram_dout
`ifdef BRAM_IO_RANGECHK_EN
    ,
    output logic        err
`endif
);
    localparam logic [7:0] LAST = 8'(LENBR);

    typedef enum logic [1:0] {IDLE, LOAD, UNLOAD} state_t;
    state_t state;

    logic [7:0]  wcnt, rcnt;
    logic        rd_done, inflight, inflight_last;
    logic [1:0]  fcnt;
    logic [11:0] fd0, fd1;
    logic        fl0, fl1;
    logic        wr_beat, pop, push, issue;
    logic [2:0]  credit;

    assign busy      = (state != IDLE);
    assign s_ready   = (state == LOAD);
    assign m_valid   = (fcnt != 2'd0);
    assign m_data    = fd0;
    assign m_last    = fl0 && m_valid;
    assign core_dout = bram_dout;

    assign wr_beat = (state == LOAD) && s_valid;
    assign pop     = m_valid && m_ready;
    assign push    = inflight;
    // Outstanding read plus queued entries must leave room once this cycle's pop is taken.
    assign credit  = 3'(fcnt) + 3'(inflight) - 3'(pop);
    assign issue   = (state == UNLOAD) && !rd_done && (credit < 3'd2);

    always_comb begin
        bram_wen   = 1'b0;
        bram_waddr = wcnt;
        bram_din   = s_data;
        bram_raddr = rcnt;
        if (state == IDLE) begin
            bram_wen   = core_wen;
            bram_waddr = core_waddr;
            bram_din   = core_din;
            bram_raddr = core_raddr;
        end else if (state == LOAD) begin
            // Gate with rst so the cycle that aborts a load writes nothing.
            bram_wen   = s_valid && !rst;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            wcnt          <= 8'd0;
            rcnt          <= 8'd0;
            rd_done       <= 1'b0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            fcnt          <= 2'd0;
            fd0           <= 12'd0;
            fd1           <= 12'd0;
            fl0           <= 1'b0;
            fl1           <= 1'b0;
            done          <= 1'b0;
        end else begin
            done          <= 1'b0;
            inflight      <= issue;
            inflight_last <= issue && (rcnt == LAST);

            // Two-entry shift FIFO, head in slot 0.
            case ({push, pop})
                2'b10: begin
                    if (fcnt == 2'd0) begin
                        fd0 <= bram_dout; fl0 <= inflight_last;
                    end else begin
                        fd1 <= bram_dout; fl1 <= inflight_last;
                    end
                end
                2'b01: begin
                    fd0 <= fd1; fl0 <= fl1;
                end
                2'b11: begin
                    if (fcnt == 2'd1) begin
                        fd0 <= bram_dout; fl0 <= inflight_last;
                    end else begin
                        fd0 <= fd1;       fl0 <= fl1;
                        fd1 <= bram_dout; fl1 <= inflight_last;
                    end
                end
                default: ;
            endcase
            fcnt <= fcnt + 2'(push) - 2'(pop);

            case (state)
                IDLE: begin
                    if (load_start) begin
                        state <= LOAD;
                        wcnt  <= 8'd0;
                    end else if (unload_start) begin
                        state   <= UNLOAD;
                        rcnt    <= 8'd0;
                        rd_done <= 1'b0;
                    end
                end
                LOAD: begin
                    if (wr_beat) begin
                        if (wcnt == LAST) begin
                            state <= IDLE;
                            done  <= 1'b1;
                            wcnt  <= 8'd0;
                        end else begin
                            wcnt <= wcnt + 8'd1;
                        end
                    end
                end
                UNLOAD: begin
                    if (issue) begin
                        if (rcnt == LAST) begin
                            rd_done <= 1'b1;
                            rcnt    <= 8'd0;
                        end else begin
                            rcnt <= rcnt + 8'd1;
                        end
                    end
                    if (pop && m_last) begin
                        state   <= IDLE;
                        done    <= 1'b1;
                        rd_done <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BRAM_IO_RANGECHK_EN
    always_ff @(posedge clk) begin
        if (rst)
            err <= 1'b0;
        else if (state == IDLE && load_start)
            err <= 1'b0;
        else if (wr_beat && s_data >= 12'd3329)
            err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_bram_io_ctrl.sv
// Directed bench for bram_io_ctrl with a behavioural 1-cycle-latency BRAM.
module tb_bram_io_ctrl;
    logic        clk = 1'b0;
    logic        rst, load_start, unload_start;
    logic        busy, done;
    logic        s_valid, s_ready;
    logic [11:0] s_data;
    logic        m_valid, m_last, m_ready;
    logic [11:0] m_data;
    logic        core_wen;
    logic [7:0]  core_waddr, core_raddr;
    logic [11:0] core_din, core_dout;
    logic        bram_wen;
    logic [7:0]  bram_waddr, bram_raddr;
    logic [11:0] bram_din, bram_dout;
`ifdef BRAM_IO_RANGECHK_EN
    logic        err;
`endif

    int vec  = 0;
    int miss = 0;
    logic [11:0] mem [0:255];
    int hi_writes = 0;
    bit log_en    = 1'b0;

    always #5 clk = ~clk;

    bram_io_ctrl #(.LENBR(255)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .unload_start(unload_start),
        .busy(busy), .done(done),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
        .core_wen(core_wen), .core_waddr(core_waddr), .core_din(core_din),
        .core_raddr(core_raddr), .core_dout(core_dout),
        .bram_wen(bram_wen), .bram_waddr(bram_waddr), .bram_din(bram_din),
        .bram_raddr(bram_raddr), .bram_dout(bram_dout)
`ifdef BRAM_IO_RANGECHK_EN
        , .err(err)
`endif
    );

    // BRAM model: synchronous write, registered read.
    always @(posedge clk) begin
        if (bram_wen) mem[bram_waddr] <= bram_din;
        bram_dout <= mem[bram_raddr];
        if (log_en && bram_wen && bram_waddr >= 8'd100) hi_writes <= hi_writes + 1;
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; cyc(); rst = 1'b0; #1;
        vec++; if (busy !== 1'b0)    begin miss++; $display("FAIL reset_busy got %b want 0", busy); end
        vec++; if (done !== 1'b0)    begin miss++; $display("FAIL reset_done got %b want 0", done); end
        vec++; if (m_valid !== 1'b0) begin miss++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
        vec++; if (s_ready !== 1'b0) begin miss++; $display("FAIL reset_s_ready got %b want 0", s_ready); end
        vec++; if (m_last !== 1'b0)  begin miss++; $display("FAIL reset_m_last got %b want 0", m_last); end
    endtask

    task automatic test_core_passthru();
        core_wen = 1'b1; core_waddr = 8'd7; core_din = 12'd7; core_raddr = 8'd3; #1;
        vec++; if (bram_wen !== 1'b1)    begin miss++; $display("FAIL core_wen got %b want 1", bram_wen); end
        vec++; if (bram_waddr !== 8'd7)  begin miss++; $display("FAIL core_waddr got %0d want 7", bram_waddr); end
        vec++; if (bram_din !== 12'd7)   begin miss++; $display("FAIL core_din got %0d want 7", bram_din); end
        vec++; if (bram_raddr !== 8'd3)  begin miss++; $display("FAIL core_raddr got %0d want 3", bram_raddr); end
        cyc(); core_wen = 1'b0; #1;
        vec++; if (core_dout !== bram_dout) begin miss++; $display("FAIL core_dout got %0d want %0d", core_dout, bram_dout); end
        cyc();
    endtask

    task automatic test_load();
        int dones = 0;
        load_start = 1'b1; cyc(); load_start = 1'b0;
        for (int i = 0; i < 256; i++) begin
            s_valid = 1'b1; s_data = 12'(i); #1;
            if (done) dones++;
            vec++; if (s_ready !== 1'b1 || bram_wen !== 1'b1) begin miss++; $display("FAIL load_wen beat %0d got rdy=%b wen=%b want 1,1", i, s_ready, bram_wen); end
            vec++; if (bram_waddr !== 8'(i) || bram_din !== 12'(i)) begin miss++; $display("FAIL load_addr beat %0d got a=%0d d=%0d want %0d", i, bram_waddr, bram_din, i); end
            cyc();
        end
        s_valid = 1'b0; #1;
        if (done) dones++;
        vec++; if (busy !== 1'b0) begin miss++; $display("FAIL load_idle got busy=%b want 0", busy); end
        vec++; if (done !== 1'b1) begin miss++; $display("FAIL load_done got %b want 1", done); end
        cyc();
        if (done) dones++;
        vec++; if (dones !== 1) begin miss++; $display("FAIL load_done_count got %0d want 1", dones); end
    endtask

    task automatic test_unload(input bit toggle);
        int idx = 0, n = 0, dones = 0, bubbles = 0;
        unload_start = 1'b1; m_ready = 1'b1; #1;
        vec++; if (m_valid !== 1'b0) begin miss++; $display("FAIL unload_T0 m_valid got %b want 0", m_valid); end
        cyc(); unload_start = 1'b0; #1;
        vec++; if (m_valid !== 1'b0 || busy !== 1'b1) begin miss++; $display("FAIL unload_T1 got v=%b busy=%b want 0,1", m_valid, busy); end
        cyc();
        vec++; if (m_valid !== 1'b0) begin miss++; $display("FAIL unload_T2 m_valid got %b want 0", m_valid); end
        cyc();
        vec++; if (m_valid !== 1'b1) begin miss++; $display("FAIL unload_T3 m_valid got %b want 1", m_valid); end
        while (idx < 256 && n < 2000) begin
            if (toggle) begin
                case (n % 4)
                    0, 3:    m_ready = 1'b1;
                    default: m_ready = 1'b0;
                endcase
            end
            #1;
            if (done) dones++;
            if (m_valid && m_ready) begin
                vec++; if (m_data !== 12'(idx)) begin miss++; $display("FAIL unload_data got %0d want %0d", m_data, idx); end
                vec++; if (m_last !== (idx == 255)) begin miss++; $display("FAIL unload_last idx %0d got %b want %b", idx, m_last, idx == 255); end
                idx++;
            end else if (!toggle) begin
                bubbles++;
            end
            cyc(); n++;
        end
        m_ready = 1'b0; #1;
        vec++; if (idx !== 256) begin miss++; $display("FAIL unload_count got %0d want 256", idx); end
        if (done) dones++;
        vec++; if (done !== 1'b1 || busy !== 1'b0) begin miss++; $display("FAIL unload_end got done=%b busy=%b want 1,0", done, busy); end
        cyc();
        if (done) dones++;
        vec++; if (dones !== 1) begin miss++; $display("FAIL unload_done_count got %0d want 1", dones); end
        vec++; if (m_valid !== 1'b0) begin miss++; $display("FAIL unload_drained m_valid got %b want 0", m_valid); end
        if (!toggle) begin
            vec++; if (bubbles !== 0) begin miss++; $display("FAIL unload_bubbles got %0d want 0", bubbles); end
        end
    endtask

    task automatic test_priority();
        load_start = 1'b1; unload_start = 1'b1; cyc(); load_start = 1'b0; #1;
        vec++; if (s_ready !== 1'b1 || busy !== 1'b1) begin miss++; $display("FAIL prio_load got rdy=%b busy=%b want 1,1", s_ready, busy); end
        core_wen = 1'b1; core_waddr = 8'hAA; core_din = 12'h555;
        for (int k = 0; k < 2; k++) begin
            s_valid = 1'b0; #1;
            vec++; if (bram_wen !== 1'b0) begin miss++; $display("FAIL prio_core_blocked got wen=%b want 0", bram_wen); end
            cyc();
        end
        for (int i = 0; i < 256; i++) begin
            s_valid = 1'b1; s_data = 12'(i);
            if (i == 255) unload_start = 1'b0;
            #1;
            vec++; if (bram_waddr !== 8'(i) || bram_din !== 12'(i)) begin miss++; $display("FAIL prio_beat %0d got a=%0d d=%0d want %0d", i, bram_waddr, bram_din, i); end
            cyc();
        end
        s_valid = 1'b0; core_wen = 1'b0; #1;
        vec++; if (busy !== 1'b0 || done !== 1'b1) begin miss++; $display("FAIL prio_end got busy=%b done=%b want 0,1", busy, done); end
        cyc();
        vec++; if (busy !== 1'b0) begin miss++; $display("FAIL prio_no_unload got busy=%b want 0", busy); end
    endtask

`ifdef BRAM_IO_RANGECHK_EN
    task automatic test_rangechk();
        load_start = 1'b1; cyc(); load_start = 1'b0;
        for (int i = 0; i < 256; i++) begin
            s_valid = 1'b1; s_data = (i == 5) ? 12'd3329 : 12'(i); #1;
            if (i == 5) begin
                vec++; if (err !== 1'b0) begin miss++; $display("FAIL err_before got %b want 0", err); end
            end
            if (i == 6) begin
                vec++; if (err !== 1'b1) begin miss++; $display("FAIL err_set got %b want 1", err); end
            end
            cyc();
        end
        s_valid = 1'b0; #1;
        vec++; if (err !== 1'b1 || done !== 1'b1) begin miss++; $display("FAIL err_hold got err=%b done=%b want 1,1", err, done); end
        load_start = 1'b1; cyc(); load_start = 1'b0; #1;
        vec++; if (err !== 1'b0) begin miss++; $display("FAIL err_clear got %b want 0", err); end
        for (int i = 0; i < 256; i++) begin
            s_valid = 1'b1; s_data = 12'(i); cyc();
        end
        s_valid = 1'b0; cyc();
    endtask
`endif

    task automatic test_reset_midload();
        load_start = 1'b1; cyc(); load_start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            s_valid = 1'b1; s_data = 12'(i); cyc();
        end
        log_en = 1'b1; rst = 1'b1; s_data = 12'd100; #1;
        vec++; if (bram_wen !== 1'b0) begin miss++; $display("FAIL rstload_wen got %b want 0", bram_wen); end
        cyc(); rst = 1'b0; #1;
        vec++; if (busy !== 1'b0 || s_ready !== 1'b0) begin miss++; $display("FAIL rstload_idle got busy=%b rdy=%b want 0,0", busy, s_ready); end
        for (int k = 0; k < 3; k++) cyc();
        s_valid = 1'b0; log_en = 1'b0; cyc();
        vec++; if (hi_writes !== 0) begin miss++; $display("FAIL rstload_hi_writes got %0d want 0", hi_writes); end
        vec++; if (busy !== 1'b0) begin miss++; $display("FAIL rstload_busy got %b want 0", busy); end
    endtask

    initial begin
        rst = 1'b1; load_start = 1'b0; unload_start = 1'b0;
        s_valid = 1'b0; s_data = 12'd0; m_ready = 1'b0;
        core_wen = 1'b0; core_waddr = 8'd0; core_din = 12'd0; core_raddr = 8'd0;
        cyc(); cyc();
        test_reset();
        test_core_passthru();
        test_load();
        test_unload(1'b0);
        test_unload(1'b1);
        test_priority();
        test_unload(1'b0);
`ifdef BRAM_IO_RANGECHK_EN
        test_rangechk();
`endif
        test_reset_midload();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
